// File: rtl/pll_rst_seq.sv
// PLL reset/lock sequencer on the reference clock: holds the PLL in reset, waits
// for lock with timeout and bounded retries, qualifies lock, then releases sys_rst.
module pll_rst_seq #(
  parameter int RST_HOLD_CYCLES    = 250,
  parameter int LOCK_TIMEOUT       = 25000,
  parameter int LOCK_STABLE_CYCLES = 64,
  parameter int RETRY_MAX          = 7
) (
  input  logic       refclk,
  input  logic       reset,
  input  logic       pll_lock,
  input  logic       rst_req,
  output logic       pll_reset,
  output logic       sys_rst,
  output logic       locked,
  output logic       fail,
  output logic [2:0] retry_cnt,
  output logic [2:0] state
);

  localparam int MAX_AB = (RST_HOLD_CYCLES > LOCK_TIMEOUT) ? RST_HOLD_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_C  = (MAX_AB > LOCK_STABLE_CYCLES) ? MAX_AB : LOCK_STABLE_CYCLES;
  localparam int CNT_W  = (MAX_C > 1) ? $clog2(MAX_C) : 1;

  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RST_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [2:0]       RETRY_LAST   = 3'(RETRY_MAX);

  typedef enum logic [2:0] {
    S_RESET     = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RUN       = 3'd3,
    S_FAIL      = 3'd4
  } state_t;

  state_t           st, st_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [2:0]       retry, retry_nx;
  logic             lock_p0, lock_s;

  assign state     = st;
  assign retry_cnt = retry;

  // Outputs are decoded from next-state so they move on the same edge as state.
  always_ff @(posedge refclk) begin
    if (reset) begin
      lock_p0   <= 1'b0;
      lock_s    <= 1'b0;
      st        <= S_RESET;
      cnt       <= '0;
      retry     <= '0;
      pll_reset <= 1'b1;
      sys_rst   <= 1'b1;
      locked    <= 1'b0;
      fail      <= 1'b0;
    end else begin
      lock_p0   <= pll_lock;
      lock_s    <= lock_p0;
      st        <= st_nx;
      cnt       <= cnt_nx;
      retry     <= retry_nx;
      pll_reset <= (st_nx == S_RESET);
      sys_rst   <= (st_nx != S_RUN);
      locked    <= (st_nx == S_RUN);
      fail      <= (st_nx == S_FAIL);
    end
  end

  always_comb begin
    st_nx    = st;
    cnt_nx   = cnt;
    retry_nx = retry;
    if (rst_req) begin
      st_nx    = S_RESET;
      cnt_nx   = '0;
      retry_nx = '0;
    end else begin
      case (st)
        S_RESET: begin
          if (cnt == HOLD_LAST) begin
            st_nx  = S_WAIT_LOCK;
            cnt_nx = '0;
          end else begin
            cnt_nx = cnt + CNT_W'(1);
          end
        end
        S_WAIT_LOCK: begin
          if (lock_s) begin
            st_nx  = S_STABLE;
            cnt_nx = '0;
          end else if (cnt == TIMEOUT_LAST) begin
            cnt_nx = '0;
            if (retry == RETRY_LAST) begin
              st_nx = S_FAIL;
            end else begin
              st_nx    = S_RESET;
              retry_nx = retry + 3'd1;
            end
          end else begin
            cnt_nx = cnt + CNT_W'(1);
          end
        end
        // A lock drop while qualifying restarts the wait without spending a retry.
        S_STABLE: begin
          if (!lock_s) begin
            st_nx  = S_WAIT_LOCK;
            cnt_nx = '0;
          end else if (cnt == STABLE_LAST) begin
            st_nx  = S_RUN;
            cnt_nx = '0;
          end else begin
            cnt_nx = cnt + CNT_W'(1);
          end
        end
        S_RUN: begin
          if (!lock_s) begin
            st_nx    = S_RESET;
            cnt_nx   = '0;
            retry_nx = '0;
          end
        end
        S_FAIL: begin
          st_nx = S_FAIL;
        end
        default: begin
          st_nx    = S_RESET;
          cnt_nx   = '0;
          retry_nx = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_rst_seq.sv
// Bench for pll_rst_seq: a cycle-level reference model feeds an expectation queue
// drained by a monitor, plus directed checks at the edges called out for each scenario.
module tb_pll_rst_seq;

  localparam int HOLD    = 4;
  localparam int TIMEOUT = 20;
  localparam int STABLE  = 8;
  localparam int RMAX    = 2;

  logic       refclk = 1'b0;
  logic       reset = 1'b1;
  logic       pll_lock = 1'b0;
  logic       rst_req = 1'b0;
  logic       pll_reset, sys_rst, locked, fail;
  logic [2:0] retry_cnt, state;

  typedef struct packed {
    logic [2:0] st;
    logic [2:0] rt;
    logic       pr;
    logic       sr;
    logic       lk;
    logic       fl;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  pll_rst_seq #(
    .RST_HOLD_CYCLES(HOLD),
    .LOCK_TIMEOUT(TIMEOUT),
    .LOCK_STABLE_CYCLES(STABLE),
    .RETRY_MAX(RMAX)
  ) dut (
    .refclk(refclk),
    .reset(reset),
    .pll_lock(pll_lock),
    .rst_req(rst_req),
    .pll_reset(pll_reset),
    .sys_rst(sys_rst),
    .locked(locked),
    .fail(fail),
    .retry_cnt(retry_cnt),
    .state(state)
  );

  always #5 refclk = ~refclk;

  // Reference model: phase number, edges spent in the phase, retries spent.
  // The logic sees pll_lock as sampled two edges earlier.
  always @(posedge refclk) begin : model
    int   ph;
    int   el;
    int   rt;
    bit   h1;
    bit   h2;
    bit   ls;
    exp_t e;
    ls = h2;
    h2 = h1;
    h1 = pll_lock;
    if (reset) begin
      ph = 0; el = 0; rt = 0; h1 = 0; h2 = 0;
    end else if (rst_req) begin
      ph = 0; el = 0; rt = 0;
    end else begin
      case (ph)
        0: begin
          el = el + 1;
          if (el == HOLD) begin ph = 1; el = 0; end
        end
        1: begin
          if (ls) begin
            ph = 2; el = 0;
          end else begin
            el = el + 1;
            if (el == TIMEOUT) begin
              el = 0;
              if (rt == RMAX) ph = 4;
              else begin rt = rt + 1; ph = 0; end
            end
          end
        end
        2: begin
          if (!ls) begin
            ph = 1; el = 0;
          end else begin
            el = el + 1;
            if (el == STABLE) begin ph = 3; el = 0; end
          end
        end
        3: if (!ls) begin ph = 0; el = 0; rt = 0; end
        default: ph = 4;
      endcase
    end
    e.st = 3'(ph);
    e.rt = 3'(rt);
    e.pr = (ph == 0);
    e.sr = (ph != 3);
    e.lk = (ph == 3);
    e.fl = (ph == 4);
    exp_q.push_back(e);
  end

  task automatic chk(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
    end
  endtask

  task automatic monitor_loop();
    exp_t e;
    exp_t g;
    forever begin
      @(negedge refclk);
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL model_queue: empty at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        g = {state, retry_cnt, pll_reset, sys_rst, locked, fail};
        if (g !== e) begin
          n_fail++;
          $display("FAIL outputs: got st=%0d rt=%0d pr=%b sr=%b lk=%b fl=%b expected st=%0d rt=%0d pr=%b sr=%b lk=%b fl=%b at %0t",
                   g.st, g.rt, g.pr, g.sr, g.lk, g.fl, e.st, e.rt, e.pr, e.sr, e.lk, e.fl, $time);
        end
      end
    end
  endtask

  task automatic edges(input int n);
    repeat (n) @(negedge refclk);
  endtask

  task automatic do_reset(input logic lock);
    @(negedge refclk);
    reset    = 1'b1;
    rst_req  = 1'b0;
    pll_lock = lock;
    edges(2);
    reset = 1'b0;
  endtask

  task automatic pulse_req(input string tag);
    rst_req = 1'b1;
    edges(1);
    rst_req = 1'b0;
    chk({tag, "_state"}, state, 0);
    chk({tag, "_fail"}, fail, 0);
    chk({tag, "_retry"}, retry_cnt, 0);
    chk({tag, "_pll_reset"}, pll_reset, 1);
    chk({tag, "_sys_rst"}, sys_rst, 1);
    chk({tag, "_locked"}, locked, 0);
  endtask

  initial begin
    fork
      monitor_loop();
    join_none

    // Reset state
    edges(1);
    chk("rst_state", state, 0);
    chk("rst_pll_reset", pll_reset, 1);
    chk("rst_sys_rst", sys_rst, 1);

    // Nominal lock
    do_reset(1'b1);
    edges(3);  chk("nom_pll_reset_e3", pll_reset, 1);
    edges(1);  chk("nom_pll_reset_e4", pll_reset, 0);
               chk("nom_state_e4", state, 1);
    edges(1);  chk("nom_state_e5", state, 2);
    edges(7);  chk("nom_state_e12", state, 2);
               chk("nom_sys_rst_e12", sys_rst, 1);
    edges(1);  chk("nom_state_e13", state, 3);
               chk("nom_sys_rst_e13", sys_rst, 0);
               chk("nom_locked_e13", locked, 1);
               chk("nom_retry_e13", retry_cnt, 0);

    // rst_req while running
    pulse_req("req_run");

    // Never locks, then rst_req out of fail
    do_reset(1'b0);
    edges(23); chk("nl_state_e23", state, 1);
               chk("nl_retry_e23", retry_cnt, 0);
    edges(1);  chk("nl_state_e24", state, 0);
               chk("nl_retry_e24", retry_cnt, 1);
    edges(24); chk("nl_state_e48", state, 0);
               chk("nl_retry_e48", retry_cnt, 2);
    edges(23); chk("nl_state_e71", state, 1);
    edges(1);  chk("nl_state_e72", state, 4);
               chk("nl_fail_e72", fail, 1);
               chk("nl_pll_reset_e72", pll_reset, 0);
               chk("nl_sys_rst_e72", sys_rst, 1);
    edges(30); chk("nl_state_sticky", state, 4);
               chk("nl_retry_sat", retry_cnt, 2);
    pulse_req("req_fail");

    // Unstable lock during qualification
    do_reset(1'b0);
    edges(5);  pll_lock = 1'b1;
    edges(8);  chk("un_state_e13", state, 2);
    pll_lock = 1'b0;
    edges(2);  pll_lock = 1'b1;
    edges(1);  chk("un_state_e16", state, 1);
               chk("un_retry_e16", retry_cnt, 0);
               chk("un_sys_rst_e16", sys_rst, 1);
    edges(9);  chk("un_state_e25", state, 2);
    edges(1);  chk("un_state_e26", state, 3);
               chk("un_retry_e26", retry_cnt, 0);

    // Loss of lock while running
    pll_lock = 1'b0;
    edges(3);  chk("lol_state", state, 0);
               chk("lol_pll_reset", pll_reset, 1);
               chk("lol_sys_rst", sys_rst, 1);
               chk("lol_locked", locked, 0);
               chk("lol_retry", retry_cnt, 0);
    pll_lock = 1'b1;
    edges(30); chk("lol_rerun_state", state, 3);

    // rst_req on the same edge as a wait timeout
    do_reset(1'b0);
    edges(23); rst_req = 1'b1;
    edges(1);  rst_req = 1'b0;
               chk("coll_state", state, 0);
               chk("coll_retry", retry_cnt, 0);

    // Randomized lock behaviour, restart requests and resets
    do_reset(1'b1);
    for (int i = 0; i < 1500; i++) begin
      @(negedge refclk);
      if (pll_lock) begin
        if ($urandom_range(0, 39) == 0) pll_lock = 1'b0;
      end else begin
        if ($urandom_range(0, 7) == 0) pll_lock = 1'b1;
      end
      if ($urandom_range(0, 9) == 0) pll_lock = 1'b0;
      rst_req = ($urandom_range(0, 79) == 0);
      reset   = ($urandom_range(0, 199) == 0);
    end
    rst_req = 1'b0;
    reset   = 1'b0;
    edges(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
